// File: rtl/unit_ctrl_pkg.sv
// Shared types and constants for the unit movement controller.
package unit_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNIT_SEL = 2'd1,
    MOVE     = 2'd2,
    ATTACK   = 2'd3
  } state_t;

  localparam logic [2:0] IDLE0     = 3'd0;
  localparam logic [2:0] IDLE1     = 3'd1;
  localparam logic [2:0] ATK_FIRST = 3'd2;
  localparam logic [2:0] ATK_LAST  = 3'd5;

  localparam int MAP_W_DEF = 20;
  localparam int MAP_H_DEF = 15;

endpackage

// File: rtl/grid_cursor.sv
// Map cursor register: one-tile steps, clamped at the edges, or wrapped
// around when CURSOR_WRAP_EN is defined. Callers assert at most one step.
module grid_cursor
  import unit_ctrl_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF,
  parameter int INIT  = 125
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       step_up,
  input  logic       step_down,
  input  logic       step_left,
  input  logic       step_right,
  input  logic       load,
  input  logic [8:0] load_pos,
  output logic [8:0] pos
);

  localparam logic [8:0] ROW_STEP = 9'(MAP_W);
  localparam logic [8:0] LAST_COL = 9'(MAP_W - 1);
  localparam logic [8:0] LAST_ROW = 9'(MAP_H - 1);
  localparam logic [8:0] COL_SPAN = 9'(MAP_W * (MAP_H - 1));

  logic [8:0] col;
  logic [8:0] row;
  logic [8:0] pos_d;

  assign col = 9'(pos % MAP_W);
  assign row = 9'(pos / MAP_W);

  always_comb begin
    pos_d = pos;
    if (load) begin
      pos_d = load_pos;
    end else if (step_up) begin
`ifdef CURSOR_WRAP_EN
      pos_d = (row == 9'd0) ? pos + COL_SPAN : pos - ROW_STEP;
`else
      pos_d = (row == 9'd0) ? pos : pos - ROW_STEP;
`endif
    end else if (step_down) begin
`ifdef CURSOR_WRAP_EN
      pos_d = (row == LAST_ROW) ? pos - COL_SPAN : pos + ROW_STEP;
`else
      pos_d = (row == LAST_ROW) ? pos : pos + ROW_STEP;
`endif
    end else if (step_left) begin
`ifdef CURSOR_WRAP_EN
      pos_d = (col == 9'd0) ? pos + LAST_COL : pos - 9'd1;
`else
      pos_d = (col == 9'd0) ? pos : pos - 9'd1;
`endif
    end else if (step_right) begin
`ifdef CURSOR_WRAP_EN
      pos_d = (col == LAST_COL) ? pos - LAST_COL : pos + 9'd1;
`else
      pos_d = (col == LAST_COL) ? pos : pos + 9'd1;
`endif
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) pos <= 9'(INIT);
    else     pos <= pos_d;
  end

endmodule

// File: rtl/unit_move_ctrl.sv
// Two-unit (knight/wizard) select, move and attack controller for a tile map.
// Optional CURSOR_WRAP_EN makes the cursor wrap at map edges instead of clamping.
module unit_move_ctrl
  import unit_ctrl_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int KNIGHT_INIT = 125,
  parameter int WIZARD_INIT = 167,
  parameter int CURSOR_INIT = 125,
  parameter int MOVE_RANGE  = 3
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_cancel,
  input  logic       anim_tick,
  output logic [8:0] selected_pos,
  output logic [8:0] knight_pos,
  output logic [8:0] wizard_pos,
  output logic [2:0] knight_anim,
  output logic [2:0] wizard_anim,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [8:0] ROW_STEP = 9'(MAP_W);

  function automatic logic [8:0] col_of(input logic [8:0] p);
    return 9'(p % MAP_W);
  endfunction

  function automatic logic [8:0] row_of(input logic [8:0] p);
    return 9'(p / MAP_W);
  endfunction

  function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  state_t     state_q, state_d;
  logic       actor_q, actor_d;  // 0 = knight, 1 = wizard
  logic [8:0] dest_q, dest_d;
  logic [8:0] knight_d, wizard_d;
  logic [3:0] tick_q, tick_d;
  logic [3:0] atk_q, atk_d;
  logic [2:0] knight_anim_d, wizard_anim_d;
  logic [2:0] idle_frame, atk_frame;

  logic [8:0] actor_pos, other_pos, step_pos, sel_dist;
  logic       accept, do_cancel, do_sel, nav;
  logic       go_up, go_down, go_left, go_right, cur_load;

  assign actor_pos = actor_q ? wizard_pos : knight_pos;
  assign other_pos = actor_q ? knight_pos : wizard_pos;

  // Priority resolve: cancel > sel > up > down > left > right; only while not busy.
  assign accept    = (state_q == IDLE) || (state_q == UNIT_SEL);
  assign do_cancel = accept && btn_cancel;
  assign do_sel    = accept && !btn_cancel && btn_sel;
  assign nav       = accept && !btn_cancel && !btn_sel;
  assign go_up     = nav && btn_up;
  assign go_down   = nav && !btn_up && btn_down;
  assign go_left   = nav && !btn_up && !btn_down && btn_left;
  assign go_right  = nav && !btn_up && !btn_down && !btn_left && btn_right;
  assign cur_load  = do_cancel && (state_q == UNIT_SEL);

  assign sel_dist = abs_diff(col_of(selected_pos), col_of(actor_pos))
                  + abs_diff(row_of(selected_pos), row_of(actor_pos));

  // Path is column first, then row.
  always_comb begin
    if (col_of(actor_pos) < col_of(dest_q))      step_pos = actor_pos + 9'd1;
    else if (col_of(actor_pos) > col_of(dest_q)) step_pos = actor_pos - 9'd1;
    else if (row_of(actor_pos) < row_of(dest_q)) step_pos = actor_pos + ROW_STEP;
    else                                         step_pos = actor_pos - ROW_STEP;
  end

  grid_cursor #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .INIT  (CURSOR_INIT)
  ) u_cursor (
    .clk_25MHz  (clk_25MHz),
    .rst        (rst),
    .step_up    (go_up),
    .step_down  (go_down),
    .step_left  (go_left),
    .step_right (go_right),
    .load       (cur_load),
    .load_pos   (actor_pos),
    .pos        (selected_pos)
  );

  always_comb begin
    state_d  = state_q;
    actor_d  = actor_q;
    dest_d   = dest_q;
    knight_d = knight_pos;
    wizard_d = wizard_pos;
    atk_d    = atk_q;
    tick_d   = tick_q + {3'd0, anim_tick};

    case (state_q)
      IDLE: begin
        if (do_sel && selected_pos == knight_pos) begin
          actor_d = 1'b0;
          state_d = UNIT_SEL;
        end else if (do_sel && selected_pos == wizard_pos) begin
          actor_d = 1'b1;
          state_d = UNIT_SEL;
        end
      end
      UNIT_SEL: begin
        if (do_cancel) begin
          state_d = IDLE;
        end else if (do_sel) begin
          if (selected_pos == actor_pos) begin
            state_d = IDLE;
          end else if (selected_pos == other_pos) begin
            if (sel_dist == 9'd1) begin
              state_d = ATTACK;
              atk_d   = 4'd0;
            end
          end else if (sel_dist <= 9'(MOVE_RANGE)) begin
            state_d = MOVE;
            dest_d  = selected_pos;
          end
        end
      end
      MOVE: begin
        if (anim_tick) begin
          if (actor_q) wizard_d = step_pos;
          else         knight_d = step_pos;
          if (step_pos == dest_q) state_d = IDLE;
        end
      end
      ATTACK: begin
        if (anim_tick) begin
          if (atk_q == 4'd15) state_d = IDLE;
          else                atk_d   = atk_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    idle_frame    = tick_d[3] ? IDLE1 : IDLE0;
    atk_frame     = ATK_FIRST + {1'b0, atk_d[3:2]};
    knight_anim_d = (state_d == ATTACK && !actor_d) ? atk_frame : idle_frame;
    wizard_anim_d = (state_d == ATTACK &&  actor_d) ? atk_frame : idle_frame;
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      actor_q     <= 1'b0;
      dest_q      <= 9'(KNIGHT_INIT);
      knight_pos  <= 9'(KNIGHT_INIT);
      wizard_pos  <= 9'(WIZARD_INIT);
      tick_q      <= 4'd0;
      atk_q       <= 4'd0;
      knight_anim <= IDLE0;
      wizard_anim <= IDLE0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      actor_q     <= actor_d;
      dest_q      <= dest_d;
      knight_pos  <= knight_d;
      wizard_pos  <= wizard_d;
      tick_q      <= tick_d;
      atk_q       <= atk_d;
      knight_anim <= knight_anim_d;
      wizard_anim <= wizard_anim_d;
      busy        <= (state_d == MOVE) || (state_d == ATTACK);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_unit_move_ctrl.sv
// Directed testbench for unit_move_ctrl; expectations follow the CURSOR_WRAP_EN build setting.
module tb_unit_move_ctrl;
  import unit_ctrl_pkg::*;

  localparam logic [6:0] B_UP   = 7'b0000001;
  localparam logic [6:0] B_DOWN = 7'b0000010;
  localparam logic [6:0] B_LEFT = 7'b0000100;
  localparam logic [6:0] B_RGHT = 7'b0001000;
  localparam logic [6:0] B_SEL  = 7'b0010000;
  localparam logic [6:0] B_CANC = 7'b0100000;
  localparam logic [6:0] B_TICK = 7'b1000000;

  logic       clk_25MHz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_sel = 1'b0, btn_cancel = 1'b0, anim_tick = 1'b0;
  logic [8:0] selected_pos, knight_pos, wizard_pos;
  logic [2:0] knight_anim, wizard_anim;
  logic       busy;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int tick_exp = 0;

  unit_move_ctrl dut (
    .clk_25MHz    (clk_25MHz),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_sel      (btn_sel),
    .btn_cancel   (btn_cancel),
    .anim_tick    (anim_tick),
    .selected_pos (selected_pos),
    .knight_pos   (knight_pos),
    .wizard_pos   (wizard_pos),
    .knight_anim  (knight_anim),
    .wizard_anim  (wizard_anim),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one-cycle pulses between falling edges; outputs are sampled on the next falling edge.
  task automatic press(input logic [6:0] m);
    @(negedge clk_25MHz);
    {anim_tick, btn_cancel, btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
    @(negedge clk_25MHz);
    {anim_tick, btn_cancel, btn_sel, btn_right, btn_left, btn_down, btn_up} = 7'd0;
    if (m[6]) tick_exp = (tick_exp + 1) % 16;
  endtask

  task automatic press_n(input logic [6:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic do_reset();
    @(negedge clk_25MHz);
    rst = 1'b1;
    @(negedge clk_25MHz);
    rst = 1'b0;
    tick_exp = 0;
  endtask

  function automatic int idle_frame();
    return (tick_exp >= 8) ? 1 : 0;
  endfunction

  initial begin
    // Reset state
    do_reset();
    check("rst_sel", selected_pos, 125);
    check("rst_knight", knight_pos, 125);
    check("rst_wizard", wizard_pos, 167);
    check("rst_busy", busy, 0);
    check("rst_kanim", knight_anim, 0);
    check("rst_wanim", wizard_anim, 0);
    check("rst_state", state_dbg, IDLE);

    // Move knight 125 -> 127
    press(B_SEL);
    check("mv_unitsel", state_dbg, UNIT_SEL);
    press_n(B_RGHT, 2);
    check("mv_cursor", selected_pos, 127);
    press(B_SEL);
    check("mv_state", state_dbg, MOVE);
    check("mv_busy0", busy, 1);
    check("mv_k0", knight_pos, 125);
    press(B_TICK);
    check("mv_k1", knight_pos, 126);
    check("mv_busy1", busy, 1);
    press(B_TICK);
    check("mv_k2", knight_pos, 127);
    check("mv_busy2", busy, 0);
    check("mv_idle", state_dbg, IDLE);
    check("mv_kanim", knight_anim, idle_frame());

    // Attack: knight 125 -> 147 (column first), then strike wizard at 167
    do_reset();
    press(B_SEL);
    press_n(B_RGHT, 2);
    press(B_DOWN);
    press(B_SEL);
    press_n(B_TICK, 2);
    check("atk_path_col", knight_pos, 127);
    press(B_TICK);
    check("atk_path_row", knight_pos, 147);
    check("atk_pre_idle", state_dbg, IDLE);
    press(B_SEL);
    press(B_DOWN);
    check("atk_cursor", selected_pos, 167);
    press(B_SEL);
    check("atk_state", state_dbg, ATTACK);
    check("atk_busy", busy, 1);
    check("atk_f2", knight_anim, 2);
    press(B_LEFT);
    check("atk_btn_ignored", selected_pos, 167);
    for (int k = 1; k <= 16; k++) begin
      press(B_TICK);
      if (k % 4 == 0 && k < 16) check("atk_frame", knight_anim, 2 + k / 4);
      if (k % 4 == 3) check("atk_frame_hold", knight_anim, 2 + k / 4);
      if (k % 4 == 0) check("atk_wanim", wizard_anim, idle_frame());
      if (k == 15) check("atk_busy15", busy, 1);
    end
    check("atk_end_state", state_dbg, IDLE);
    check("atk_end_busy", busy, 0);
    check("atk_end_kanim", knight_anim, idle_frame());
    check("atk_wizard_pos", wizard_pos, 167);

    // Illegal destination, then cancel restores cursor
    do_reset();
    press(B_SEL);
    press_n(B_RGHT, 4);
    check("ill_cursor", selected_pos, 129);
    press(B_SEL);
    check("ill_state", state_dbg, UNIT_SEL);
    check("ill_busy", busy, 0);
    press(B_CANC);
    check("ill_cancel_state", state_dbg, IDLE);
    check("ill_cancel_sel", selected_pos, 125);

    // Priority: sel beats up in IDLE; cancel beats up in UNIT_SEL
    press(B_SEL | B_UP);
    check("pri_sel_state", state_dbg, UNIT_SEL);
    check("pri_sel_cursor", selected_pos, 125);
    press(B_CANC | B_UP);
    check("pri_canc_state", state_dbg, IDLE);
    check("pri_canc_cursor", selected_pos, 125);

    // Abort a move with reset
    press(B_SEL);
    press(B_RGHT);
    press(B_SEL);
    press(B_TICK);
    check("abt_k1", knight_pos, 126);
    do_reset();
    check("abt_knight", knight_pos, 125);
    check("abt_busy", busy, 0);
    check("abt_state", state_dbg, IDLE);
    check("abt_sel", selected_pos, 125);
    press(B_TICK);
    check("abt_no_step", knight_pos, 125);

    // Edges at tile 0
    do_reset();
    press_n(B_LEFT, 5);
    press_n(B_UP, 6);
    check("edge_origin", selected_pos, 0);
    press(B_UP);
`ifdef CURSOR_WRAP_EN
    check("edge_up", selected_pos, 280);
`else
    check("edge_up", selected_pos, 0);
`endif
    do_reset();
    press_n(B_LEFT, 5);
    press_n(B_UP, 6);
    press(B_LEFT);
`ifdef CURSOR_WRAP_EN
    check("edge_left", selected_pos, 19);
`else
    check("edge_left", selected_pos, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
